add_rs_station: RTL and testbench

- Reservation station for the add/sub functional unit in the Tomasulo core. Sits directly downstream of the issue stage.
- Accepts one renamed instruction per cycle into a small entry pool. Captures missing source operands by snooping the common data bus (CDB).
- Dispatches the oldest fully ready entry to the adder through a valid/ready handshake.
- Reports occupancy back to issue, replacing issue's add_count bookkeeping.

---
 rtl/add_rs_station.sv | 174 +++++++++++++++++
 tb/tb_add_rs_station.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/add_rs_station.sv
// add_rs_station: add/sub reservation station, CDB snoop, oldest-ready dispatch.
// Optional issue-stall counter is built when RS_STALL_CNT_EN is defined.
module add_rs_station #(
    parameter int DEPTH  = 3,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int FUNC_W = 4
) (
    input  logic                       clk1,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       iss_valid,
    input  logic [FUNC_W-1:0]          iss_func,
    input  logic [TAG_W-1:0]           iss_rob,
    input  logic                       iss_j_busy,
    input  logic [DATA_W-1:0]          iss_j_val,
    input  logic                       iss_k_busy,
    input  logic [DATA_W-1:0]          iss_k_val,
    output logic                       iss_ready,
    output logic [$clog2(DEPTH+1)-1:0] rs_count,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [FUNC_W-1:0]          ex_func,
    output logic [DATA_W-1:0]          ex_vj,
    output logic [DATA_W-1:0]          ex_vk,
    output logic [TAG_W-1:0]           ex_rob,
    output logic [15:0]                stall_cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] AMAX = AW'(DEPTH - 1);

    logic [DEPTH-1:0]  busy, qj_busy, qk_busy, elig;
    logic [FUNC_W-1:0] func [DEPTH];
    logic [TAG_W-1:0]  rob  [DEPTH];
    logic [TAG_W-1:0]  qj   [DEPTH];
    logic [TAG_W-1:0]  qk   [DEPTH];
    logic [DATA_W-1:0] vj   [DEPTH];
    logic [DATA_W-1:0] vk   [DEPTH];
    logic [AW-1:0]     age  [DEPTH];
    logic [AW-1:0]     age_nx [DEPTH];
    logic [CW-1:0]     count;

    logic          sel_vld, func_ok, accept, fire, j_hit, k_hit;
    logic [AW-1:0] sel, best, free_idx;

    assign elig      = busy & ~qj_busy & ~qk_busy;
    assign iss_ready = (count != CW'(DEPTH));
    assign rs_count  = count;
    assign func_ok   = (iss_func == '0) || (iss_func == FUNC_W'(1));
    assign accept    = iss_valid && iss_ready && func_ok;
    assign fire      = sel_vld && ex_ready;
    assign j_hit     = iss_j_busy && cdb_valid
                       && (cdb_tag == iss_j_val[TAG_W-1:0]);
    assign k_hit     = iss_k_busy && cdb_valid
                       && (cdb_tag == iss_k_val[TAG_W-1:0]);

    // oldest eligible entry wins; ages are unique among busy entries
    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        best    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && (!sel_vld || age[i] > best)) begin
                sel_vld = 1'b1;
                sel     = AW'(i);
                best    = age[i];
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = AW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_nx[i] = age[i];
            if (accept && age[i] != AMAX) age_nx[i] = age[i] + 1'b1;
            if (fire && age[i] > best) age_nx[i] = age_nx[i] - 1'b1;
        end
    end

    always_comb begin
        ex_valid = sel_vld;
        ex_func  = '0;
        ex_vj    = '0;
        ex_vk    = '0;
        ex_rob   = '0;
        if (sel_vld) begin
            ex_func = func[sel];
            ex_vj   = vj[sel];
            ex_vk   = vk[sel];
            ex_rob  = rob[sel];
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func[i] <= '0;
                rob[i]  <= '0;
                qj[i]   <= '0;
                qk[i]   <= '0;
                vj[i]   <= '0;
                vk[i]   <= '0;
                age[i]  <= '0;
            end
        end else if (flush) begin
            busy  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i]) begin
                    age[i] <= age_nx[i];
                    if (qj_busy[i] && cdb_valid && qj[i] == cdb_tag) begin
                        qj_busy[i] <= 1'b0;
                        vj[i]      <= cdb_data;
                    end
                    if (qk_busy[i] && cdb_valid && qk[i] == cdb_tag) begin
                        qk_busy[i] <= 1'b0;
                        vk[i]      <= cdb_data;
                    end
                end
            end
            if (fire) begin
                busy[sel] <= 1'b0;
                age[sel]  <= '0;
            end
            if (accept) begin
                busy[free_idx]    <= 1'b1;
                func[free_idx]    <= iss_func;
                rob[free_idx]     <= iss_rob;
                age[free_idx]     <= '0;
                qj_busy[free_idx] <= iss_j_busy && !j_hit;
                qj[free_idx]      <= iss_j_val[TAG_W-1:0];
                vj[free_idx]      <= j_hit ? cdb_data : iss_j_val;
                qk_busy[free_idx] <= iss_k_busy && !k_hit;
                qk[free_idx]      <= iss_k_val[TAG_W-1:0];
                vk[free_idx]      <= k_hit ? cdb_data : iss_k_val;
            end
            if (accept && !fire) count <= count + 1'b1;
            else if (fire && !accept) count <= count - 1'b1;
        end
    end

`ifdef RS_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (iss_valid && !iss_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_add_rs_station.sv
// tb_add_rs_station: random + directed stimulus against an issue-ordered
// list model; dispatched entries are checked by a scoreboard monitor.
module tb_add_rs_station;
    localparam int DEPTH = 3;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        iss_valid = 1'b0;
    logic [3:0]  iss_func = '0;
    logic [2:0]  iss_rob = '0;
    logic        iss_j_busy = 1'b0;
    logic [15:0] iss_j_val = '0;
    logic        iss_k_busy = 1'b0;
    logic [15:0] iss_k_val = '0;
    logic        iss_ready;
    logic [1:0]  rs_count;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag = '0;
    logic [15:0] cdb_data = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [3:0]  ex_func;
    logic [15:0] ex_vj, ex_vk;
    logic [2:0]  ex_rob;
    logic [15:0] stall_cnt;

    add_rs_station dut (
        .clk1(clk1), .rst_n(rst_n), .flush(flush),
        .iss_valid(iss_valid), .iss_func(iss_func), .iss_rob(iss_rob),
        .iss_j_busy(iss_j_busy), .iss_j_val(iss_j_val),
        .iss_k_busy(iss_k_busy), .iss_k_val(iss_k_val),
        .iss_ready(iss_ready), .rs_count(rs_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_func(ex_func),
        .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_rob(ex_rob),
        .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [3:0]  f;
        logic [2:0]  rob;
        bit          jb;
        logic [2:0]  jt;
        logic [15:0] jv;
        bit          kb;
        logic [2:0]  kt;
        logic [15:0] kv;
    } ent_t;

    typedef struct packed {
        logic [3:0]  f;
        logic [15:0] j;
        logic [15:0] k;
        logic [2:0]  r;
    } exp_t;

    ent_t m[$];
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_stall = 0;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // scoreboard monitor: every accepted dispatch must match the next expectation
    always @(negedge clk1) begin
        exp_t got, want;
        #3;
        if (rst_n && ex_valid && ex_ready && !flush) begin
            got = '{ex_func, ex_vj, ex_vk, ex_rob};
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dispatch: got %0h want none", got);
            end else begin
                want = exp_q.pop_front();
                chk("dispatch", 64'(got), 64'(want));
            end
        end
    end

    task automatic cyc(input bit v, input logic [3:0] f, input logic [2:0] rob,
                       input bit jb, input logic [15:0] jv,
                       input bit kb, input logic [15:0] kv,
                       input bit cv, input logic [2:0] ct, input logic [15:0] cd,
                       input bit rdy, input bit fl);
        int   oi;
        ent_t e;
        @(negedge clk1);
        iss_valid = v;   iss_func = f;   iss_rob = rob;
        iss_j_busy = jb; iss_j_val = jv;
        iss_k_busy = kb; iss_k_val = kv;
        cdb_valid = cv;  cdb_tag = ct;   cdb_data = cd;
        ex_ready = rdy;  flush = fl;
        #1;
        oi = -1;
        foreach (m[i]) if (oi < 0 && !m[i].jb && !m[i].kb) oi = i;
        chk("ex_valid", 64'(ex_valid), 64'(oi >= 0));
        chk("iss_ready", 64'(iss_ready), 64'(m.size() < DEPTH));
        chk("rs_count", 64'(rs_count), 64'(m.size()));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        if (oi < 0) chk("ex_idle", 64'({ex_func, ex_vj, ex_vk, ex_rob}), 64'(0));
`ifdef RS_STALL_CNT_EN
        if (v && m.size() == DEPTH && exp_stall < 65535) exp_stall++;
`endif
        if (fl) begin
            m.delete();
        end else begin
            bit acc;
            acc = v && m.size() < DEPTH && (f == 4'd0 || f == 4'd1);
            if (oi >= 0 && rdy)
                exp_q.push_back('{m[oi].f, m[oi].jv, m[oi].kv, m[oi].rob});
            foreach (m[i]) begin
                if (cv && m[i].jb && m[i].jt == ct) begin
                    m[i].jb = 0; m[i].jv = cd;
                end
                if (cv && m[i].kb && m[i].kt == ct) begin
                    m[i].kb = 0; m[i].kv = cd;
                end
            end
            if (oi >= 0 && rdy) m.delete(oi);
            if (acc) begin
                e.f = f; e.rob = rob;
                e.jb = jb; e.jt = jv[2:0]; e.jv = jv;
                e.kb = kb; e.kt = kv[2:0]; e.kv = kv;
                if (jb && cv && ct == jv[2:0]) begin e.jb = 0; e.jv = cd; end
                if (kb && cv && ct == kv[2:0]) begin e.kb = 0; e.kv = cd; end
                m.push_back(e);
            end
        end
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 4'd0, 3'd0, 0, 16'd0, 0, 16'd0, 0, 3'd0, 16'd0, rdy, 0);
    endtask

    task automatic do_reset();
        iss_valid = 0; cdb_valid = 0; ex_ready = 0; flush = 0;
        rst_n = 0;
        #1;
        chk("rst_ex_valid", 64'(ex_valid), 64'(0));
        chk("rst_count", 64'(rs_count), 64'(0));
        chk("rst_iss_ready", 64'(iss_ready), 64'(1));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        m.delete();
        exp_stall = 0;
        @(negedge clk1);
        rst_n = 1;
    endtask

    initial begin
        logic [3:0] f;
        repeat (2) @(negedge clk1);
        do_reset();
        // add 5+7 -> rob 2
        cyc(1, 4'd0, 3'd2, 0, 16'd5, 0, 16'd7, 0, 3'd0, 16'd0, 0, 0);
        idle(1);
        idle(0);
        // sub waiting on tag 4, woken by broadcast
        cyc(1, 4'd1, 3'd3, 1, 16'd4, 0, 16'd1, 0, 3'd0, 16'd0, 0, 0);
        idle(1);
        cyc(0, 4'd0, 3'd0, 0, 16'd0, 0, 16'd0, 1, 3'd4, 16'h0010, 1, 0);
        idle(1);
        // same-cycle bypass on tag 3
        cyc(1, 4'd0, 3'd6, 1, 16'd3, 0, 16'd2, 1, 3'd3, 16'd9, 0, 0);
        idle(1);
        // fill, stall, simultaneous wakeup of rob 1 then rob 5
        cyc(1, 4'd0, 3'd1, 1, 16'd6, 0, 16'd1, 0, 3'd0, 16'd0, 0, 0);
        cyc(1, 4'd1, 3'd5, 0, 16'd2, 1, 16'd6, 0, 3'd0, 16'd0, 0, 0);
        cyc(1, 4'd0, 3'd0, 1, 16'd7, 0, 16'd3, 0, 3'd0, 16'd0, 0, 0);
        repeat (3) cyc(1, 4'd0, 3'd4, 0, 16'd1, 0, 16'd1, 0, 3'd0, 16'd0, 0, 0);
        cyc(0, 4'd0, 3'd0, 0, 16'd0, 0, 16'd0, 1, 3'd6, 16'h00AA, 0, 0);
        idle(1);
        idle(1);
        cyc(0, 4'd0, 3'd0, 0, 16'd0, 0, 16'd0, 1, 3'd7, 16'h0077, 0, 0);
        idle(1);
        // illegal func ignored
        cyc(1, 4'd5, 3'd2, 0, 16'd1, 0, 16'd1, 0, 3'd0, 16'd0, 0, 0);
        idle(0);
        // flush with two ready entries while adder is ready
        cyc(1, 4'd0, 3'd1, 0, 16'd11, 0, 16'd12, 0, 3'd0, 16'd0, 0, 0);
        cyc(1, 4'd1, 3'd2, 0, 16'd13, 0, 16'd14, 0, 3'd0, 16'd0, 0, 0);
        cyc(0, 4'd0, 3'd0, 0, 16'd0, 0, 16'd0, 0, 3'd0, 16'd0, 1, 1);
        idle(1);
        // async reset mid-cycle with a ready entry on offer
        cyc(1, 4'd0, 3'd3, 0, 16'd21, 0, 16'd22, 0, 3'd0, 16'd0, 0, 0);
        idle(0);
        @(posedge clk1);
        #2;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15))
                                            : 4'($urandom_range(0, 1));
            cyc($urandom_range(0, 1) == 1, f, 3'($urandom),
                $urandom_range(0, 9) < 4, 16'($urandom),
                $urandom_range(0, 9) < 4, 16'($urandom),
                $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
                $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end
        for (int n = 0; n < 8; n++)
            cyc(0, 4'd0, 3'd0, 0, 16'd0, 0, 16'd0, 1, 3'(n), 16'(n), 1, 0);
        repeat (2) idle(1);
        @(negedge clk1);
        #5;
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
